// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - load/store stage with a wait-stated, word-organised byte-addressable RAM
//
// Purpose:
//   Takes the ALU sum as a byte address and performs RV32 byte/half/word loads
//   and stores on an internal RAM of 2**ADDR_WIDTH bytes. Each access costs
//   LATENCY+1 stall cycles; the load result appears for one cycle in DONE.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   addr         byte address (only addr[ADDR_WIDTH-1:0] decoded, RAM wraps)
//   wdata        store data
//   mem_read     load request
//   mem_write    store request (wins when both requests are high)
//   funct3       000 B, 001 H, 010 W, 100 BU, 101 HU, anything else = word
//   stall        hold the pipeline: accept cycle plus every BUSY cycle
//   rdata        load result, held between loads
//   rdata_valid  one-cycle pulse with a completed load
//   misalign     one-cycle pulse for a trapped misaligned access
//
// Configuration:
//   MISALIGN_TRAP_EN  defined: misaligned H/W accesses skip the RAM and pulse
//                     misalign with rdata=0. Undefined: low address bits are
//                     forced aligned and misalign stays 0.
//
// WIDTH is fixed at 32: lane selection and replication assume four byte lanes.

module data_mem_unit #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  output logic             stall,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_valid,
  output logic             misalign
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
  // The counter is loaded with LATENCY-1 so that BUSY lasts exactly LATENCY
  // cycles: the access happens in the BUSY cycle that sees the counter at 0.
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0]      lat_wdata;
  logic [2:0]            lat_f3;
  logic                  lat_wr;

  logic [WIDTH-1:0]      ram [WORDS];

  logic                  req;
  logic                  accept;
  logic                  direct;
  logic                  access;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [WIDTH-1:0]      a_wdata;
  logic [2:0]            a_f3;
  logic                  a_wr;
  logic                  sz_b;
  logic                  sz_h;
  logic                  sz_w;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic                  trap;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [1:0]            lane;
  logic [3:0]            be;
  logic [WIDTH-1:0]      wd_rep;
  logic                  ram_we;
  logic [WIDTH-1:0]      rword;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic [WIDTH-1:0]      load_val;
  logic                  unused_addr_bits;

  // Bits above the decoded range are intentionally ignored (address wraps).
  assign unused_addr_bits = ^addr[WIDTH-1:ADDR_WIDTH];

  assign req    = mem_read | mem_write;
  // rst gates accept so a zero-latency store cannot slip into the RAM while
  // the unit is being held in reset.
  assign accept = !rst && (state == IDLE) && req;
  // With LATENCY=0 the access happens on the accept edge, straight from the
  // request inputs; otherwise it uses the copy latched at accept.
  assign direct = accept && (LATENCY == 0);
  assign access = direct || (state == BUSY && cnt == 4'd0);

  assign stall  = !rst && (accept || state == BUSY);

  assign a_addr  = direct ? addr[ADDR_WIDTH-1:0] : lat_addr;
  assign a_wdata = direct ? wdata                : lat_wdata;
  assign a_f3    = direct ? funct3               : lat_f3;
  assign a_wr    = direct ? mem_write            : lat_wr;

  // Size decode: funct3[1:0] picks the size, funct3[2] means unsigned.
  // The reserved encodings (x11, 110) fall through to word.
  assign sz_b = (a_f3[1:0] == 2'b00);
  assign sz_h = (a_f3[1:0] == 2'b01);
  assign sz_w = !(sz_b || sz_h);

`ifdef MISALIGN_TRAP_EN
  assign trap     = (sz_h && a_addr[0]) || (sz_w && a_addr[1:0] != 2'b00);
  assign eff_addr = a_addr;
`else
  assign trap     = 1'b0;
  assign eff_addr = {a_addr[ADDR_WIDTH-1:2],
                     sz_w ? 1'b0 : a_addr[1],
                     sz_b ? a_addr[0] : 1'b0};
`endif

  assign word_idx = eff_addr[ADDR_WIDTH-1:2];
  assign lane     = eff_addr[1:0];

  // Store data is replicated across lanes so the byte enables alone pick
  // which bytes of the word get overwritten.
  always_comb begin
    be     = 4'b1111;
    wd_rep = a_wdata;
    if (sz_b) begin
      be     = 4'b0001 << lane;
      wd_rep = {4{a_wdata[7:0]}};
    end else if (sz_h) begin
      be     = lane[1] ? 4'b1100 : 4'b0011;
      wd_rep = {2{a_wdata[15:0]}};
    end
  end

  assign ram_we = access && a_wr && !trap;

  // RAM contents survive reset; only the control path is reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          ram[word_idx][8*i +: 8] <= wd_rep[8*i +: 8];
        end
      end
    end
  end

  assign rword = ram[word_idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_val = rword;
    if (sz_b) begin
      load_val = a_f3[2] ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
    end else if (sz_h) begin
      load_val = a_f3[2] ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_f3      <= 3'd0;
      lat_wr      <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      misalign    <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            lat_addr  <= addr[ADDR_WIDTH-1:0];
            lat_wdata <= wdata;
            lat_f3    <= funct3;
            lat_wr    <= mem_write;
            cnt       <= CNT_INIT;
            state     <= (LATENCY == 0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // Request inputs are ignored here; a new access starts from IDLE.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Outputs for DONE are registered on the edge that enters DONE.
      if (access) begin
        if (trap) begin
          misalign <= 1'b1;
          rdata    <= '0;
        end else if (!a_wr) begin
          rdata       <= load_val;
          rdata_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// tb/tb_data_mem_unit.sv - randomized bench for data_mem_unit against a byte-array reference model
`timescale 1ns/1ps

module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mem_read;
  logic [1:0]  mem_write;
  logic [1:0]  stall_v;
  logic [1:0]  valid_v;
  logic [1:0]  mis_v;
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [31:0] rdata_v [2];
  logic [2:0]  f3_v    [2];

  // Instance 0 runs with LATENCY=2, instance 1 with LATENCY=0.
  data_mem_unit #(.WIDTH(32), .ADDR_WIDTH(12), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst), .addr(addr_v[0]), .wdata(wdata_v[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .funct3(f3_v[0]),
    .stall(stall_v[0]), .rdata(rdata_v[0]), .rdata_valid(valid_v[0]),
    .misalign(mis_v[0])
  );

  data_mem_unit #(.WIDTH(32), .ADDR_WIDTH(12), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst(rst), .addr(addr_v[1]), .wdata(wdata_v[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .funct3(f3_v[1]),
    .stall(stall_v[1]), .rdata(rdata_v[1]), .rdata_valid(valid_v[1]),
    .misalign(mis_v[1])
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  bit          checking = 1'b0;

  logic        exp_stall [2];
  logic        exp_valid [2];
  logic        exp_mis   [2];
  logic [31:0] exp_rdata [2];
  logic [7:0]  mm [2][4096];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dut%0d stall", d), {31'd0, stall_v[d]}, {31'd0, exp_stall[d]});
        chk($sformatf("dut%0d rdata_valid", d), {31'd0, valid_v[d]}, {31'd0, exp_valid[d]});
        chk($sformatf("dut%0d misalign", d), {31'd0, mis_v[d]}, {31'd0, exp_mis[d]});
        chk($sformatf("dut%0d rdata", d), rdata_v[d], exp_rdata[d]);
      end
    end
  end

  task automatic idle_inputs(input int d);
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    addr_v[d]    = 32'd0;
    wdata_v[d]   = 32'd0;
    f3_v[d]      = 3'd0;
  endtask

  task automatic random_inputs(input int d);
    mem_read[d]  = 1'($urandom);
    mem_write[d] = 1'($urandom);
    addr_v[d]    = $urandom;
    wdata_v[d]   = $urandom;
    f3_v[d]      = 3'($urandom);
  endtask

  task automatic reset_exp();
    for (int d = 0; d < 2; d++) begin
      idle_inputs(d);
      exp_stall[d] = 1'b0;
      exp_valid[d] = 1'b0;
      exp_mis[d]   = 1'b0;
      exp_rdata[d] = 32'd0;
    end
  endtask

  // Reference behaviour of one access, as seen in the DONE cycle.
  task automatic model_op(input int d, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
    int          sz;
    int          ba;
    logic [31:0] v;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ba = int'(a[11:0]);
    exp_stall[d] = 1'b0;
    exp_valid[d] = 1'b0;
    exp_mis[d]   = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (ba % sz != 0) begin
      exp_mis[d]   = 1'b1;
      exp_rdata[d] = 32'd0;
      return;
    end
`else
    ba = ba - (ba % sz);
`endif
    if (wr) begin
      for (int k = 0; k < sz; k++) mm[d][ba + k] = wd[8*k +: 8];
    end else begin
      v = 32'd0;
      for (int k = 0; k < sz; k++) v[8*k +: 8] = mm[d][ba + k];
      if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      exp_rdata[d] = v;
      exp_valid[d] = 1'b1;
    end
  endtask

  // Starts and ends #1 after a rising edge, inputs idle on exit.
  task automatic access(input int d, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got, output int nstall, output int nvalid,
                        output bit gotmis);
    int lat;
    lat    = (d == 0) ? 2 : 0;
    nstall = 0;
    nvalid = 0;
    mem_read[d]  = rd;
    mem_write[d] = wr;
    f3_v[d]      = f3;
    addr_v[d]    = a;
    wdata_v[d]   = wd;
    exp_stall[d] = 1'b1;
    exp_valid[d] = 1'b0;
    exp_mis[d]   = 1'b0;
    @(negedge clk);
    if (stall_v[d]) nstall++;
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      random_inputs(d);
      @(negedge clk);
      if (stall_v[d]) nstall++;
    end
    @(posedge clk); #1;
    random_inputs(d);
    model_op(d, wr, f3, a, wd);
    @(negedge clk);
    if (stall_v[d]) nstall++;
    if (valid_v[d]) nvalid++;
    got    = rdata_v[d];
    gotmis = mis_v[d];
    @(posedge clk); #1;
    idle_inputs(d);
    exp_stall[d] = 1'b0;
    exp_valid[d] = 1'b0;
    exp_mis[d]   = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int          ns;
    int          nv;
    bit          gm;
    int          d;
    int          op;
    logic [31:0] a;

    reset_exp();
    checking = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset stall", {31'd0, stall_v[0]}, 32'd0);
    chk("reset rdata", rdata_v[0], 32'd0);
    chk("reset rdata_valid", {31'd0, valid_v[0]}, 32'd0);
    chk("reset misalign", {31'd0, mis_v[0]}, 32'd0);
    rst = 1'b0;

    // Give the exercised region 0x000-0x0FF defined contents in both RAMs.
    for (int dd = 0; dd < 2; dd++) begin
      for (int w = 0; w < 64; w++) begin
        access(dd, 1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom, got, ns, nv, gm);
      end
    end

    // LATENCY=2 word store/load.
    access(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, got, ns, nv, gm);
    chk("t1 sw stall cycles", 32'(ns), 32'd3);
    access(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, got, ns, nv, gm);
    chk("t1 lw data", got, 32'hDEADBEEF);
    chk("t1 lw valid pulses", 32'(nv), 32'd1);
    chk("t1 lw stall cycles", 32'(ns), 32'd3);

    // Byte store into the middle of a word.
    access(0, 1'b0, 1'b1, 3'b000, 32'h11, 32'h00000080, got, ns, nv, gm);
    access(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, got, ns, nv, gm);
    chk("t2 lw after sb", got, 32'hDEAD80EF);
    access(0, 1'b1, 1'b0, 3'b000, 32'h11, 32'h0, got, ns, nv, gm);
    chk("t2 lb", got, 32'hFFFFFF80);
    access(0, 1'b1, 1'b0, 3'b100, 32'h11, 32'h0, got, ns, nv, gm);
    chk("t2 lbu", got, 32'h00000080);

    // Half store on the upper lane pair.
    access(0, 1'b0, 1'b1, 3'b001, 32'h22, 32'h00008001, got, ns, nv, gm);
    access(0, 1'b1, 1'b0, 3'b001, 32'h22, 32'h0, got, ns, nv, gm);
    chk("t3 lh", got, 32'hFFFF8001);
    access(0, 1'b1, 1'b0, 3'b101, 32'h22, 32'h0, got, ns, nv, gm);
    chk("t3 lhu", got, 32'h00008001);
    access(0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, got, ns, nv, gm);
    chk("t3 lw upper half", {16'd0, got[31:16]}, 32'h00008001);

    // LATENCY=0 instance.
    access(1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h11223344, got, ns, nv, gm);
    access(1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, got, ns, nv, gm);
    chk("t4 lw data", got, 32'h11223344);
    chk("t4 lw stall cycles", 32'(ns), 32'd1);
    chk("t4 lw valid pulses", 32'(nv), 32'd1);
    access(1, 1'b1, 1'b1, 3'b010, 32'h44, 32'hA5A5A5A5, got, ns, nv, gm);
    chk("t4 rd+wr no valid", 32'(nv), 32'd0);
    access(1, 1'b1, 1'b0, 3'b010, 32'h44, 32'h0, got, ns, nv, gm);
    chk("t4 rd+wr store done", got, 32'hA5A5A5A5);

    // Reset in the middle of a store discards it.
    access(0, 1'b0, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, got, ns, nv, gm);
    mem_read[0]  = 1'b0;
    mem_write[0] = 1'b1;
    f3_v[0]      = 3'b010;
    addr_v[0]    = 32'h30;
    wdata_v[0]   = 32'h12345678;
    exp_stall[0] = 1'b1;
    @(posedge clk); #1;
    idle_inputs(0);
    @(posedge clk); #1;
    rst = 1'b1;
    reset_exp();
    #1;
    chk("t5 stall drops at reset", {31'd0, stall_v[0]}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    access(0, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, got, ns, nv, gm);
    chk("t5 old value kept", got, 32'hCAFEF00D);

    // Misaligned word load and address aliasing.
    access(0, 1'b1, 1'b0, 3'b010, 32'h13, 32'h0, got, ns, nv, gm);
`ifdef MISALIGN_TRAP_EN
    chk("t6 misalign pulse", {31'd0, gm}, 32'd1);
    chk("t6 trapped rdata", got, 32'd0);
`else
    chk("t6 aligned read", got, 32'hDEAD80EF);
    chk("t6 no misalign", {31'd0, gm}, 32'd0);
`endif
    chk("t6 lw stall cycles", 32'(ns), 32'd3);
    access(0, 1'b1, 1'b0, 3'b010, 32'h1010, 32'h0, got, ns, nv, gm);
    chk("t6 alias 0x1010", got, 32'hDEAD80EF);

    // Randomized traffic within the initialised region, upper bits random.
    for (int n = 0; n < 300; n++) begin
      d  = $urandom_range(0, 1);
      op = $urandom_range(0, 9);
      a  = $urandom & 32'hFFFF_F0FF;
      access(d, (op < 5) || (op == 9), op >= 5, 3'($urandom_range(0, 7)), a, $urandom,
             got, ns, nv, gm);
      chk("rand stall cycles", 32'(ns), (d == 0) ? 32'd3 : 32'd1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
